rv_iommu_ctx_cache: RTL and testbench

// Generic fully-associative context cache for the IOMMU translation logic.
// One block serves as DDTC (USE_PID=0) or PDTC (USE_PID=1), with parametrised tag and content widths.

---
 rtl/rv_iommu_ctx_cache_if.sv | 37 +++
 rtl/rv_iommu_ctx_cache.sv | 134 +++++++++++++
 tb/tb_rv_iommu_ctx_cache.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_iommu_ctx_cache_if.sv
// rv_iommu_ctx_cache_if: flush, fill and lookup signals of the IOMMU context cache
interface rv_iommu_ctx_cache_if #(
   parameter int unsigned DID_W     = 24,
   parameter int unsigned PID_W     = 20,
   parameter int unsigned CONTENT_W = 64
);
   logic                 flush_i;
   logic                 flush_dv_i;
   logic                 flush_pv_i;
   logic [DID_W-1:0]     flush_did_i;
   logic [PID_W-1:0]     flush_pid_i;
   logic                 update_i;
   logic [DID_W-1:0]     up_did_i;
   logic [PID_W-1:0]     up_pid_i;
   logic [CONTENT_W-1:0] up_content_i;
   logic                 lu_req_i;
   logic [DID_W-1:0]     lu_did_i;
   logic [PID_W-1:0]     lu_pid_i;
   logic                 lu_gnt_o;
   logic                 lu_valid_o;
   logic                 lu_hit_o;
   logic [CONTENT_W-1:0] lu_content_o;

   modport master (
      output flush_i, flush_dv_i, flush_pv_i, flush_did_i, flush_pid_i,
      output update_i, up_did_i, up_pid_i, up_content_i,
      output lu_req_i, lu_did_i, lu_pid_i,
      input  lu_gnt_o, lu_valid_o, lu_hit_o, lu_content_o
   );

   modport slave (
      input  flush_i, flush_dv_i, flush_pv_i, flush_did_i, flush_pid_i,
      input  update_i, up_did_i, up_pid_i, up_content_i,
      input  lu_req_i, lu_did_i, lu_pid_i,
      output lu_gnt_o, lu_valid_o, lu_hit_o, lu_content_o
   );
endinterface

// File: rtl/rv_iommu_ctx_cache.sv
// rv_iommu_ctx_cache: fully-associative DDTC/PDTC context cache with tree-PLRU replacement.
// Define RV_IOMMU_CTX_CACHE_PERF_EN to add saturating hit/miss counters.
module rv_iommu_ctx_cache #(
   parameter int unsigned ENTRIES   = 8,
   parameter int unsigned DID_W     = 24,
   parameter int unsigned PID_W     = 20,
   parameter int unsigned CONTENT_W = 64,
   parameter bit          USE_PID   = 1'b1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   rv_iommu_ctx_cache_if.slave  bus
`ifdef RV_IOMMU_CTX_CACHE_PERF_EN
   ,
   input  logic                 perf_clr_i,
   output logic [CNT_W-1:0]     hit_cnt_o,
   output logic [CNT_W-1:0]     miss_cnt_o
`endif
);
   localparam int unsigned LVL   = $clog2(ENTRIES);
   localparam int unsigned IDX_W = LVL;

   logic [ENTRIES-1:0]   valid_q;
   logic [DID_W-1:0]     did_q  [ENTRIES];
   logic [PID_W-1:0]     pid_q  [ENTRIES];
   logic [CONTENT_W-1:0] data_q [ENTRIES];
   logic [ENTRIES-2:0]   plru_q, plru_d;
   logic [ENTRIES-1:0]   lu_match, up_match, fl_match;
   logic [IDX_W-1:0]     lu_idx, up_idx, inv_idx, vic;
   logic                 do_up, acc, same_tag, hit;
   logic                 lu_valid_q, lu_hit_q;
   logic [CONTENT_W-1:0] lu_content_q;

   // Point every node on the leaf's path away from it (bit 1 = right subtree).
   function automatic logic [ENTRIES-2:0] touch(input logic [ENTRIES-2:0] t, input logic [IDX_W-1:0] leaf);
      logic [IDX_W:0] p;
      touch = t;
      p = {1'b1, leaf};
      for (int l = 0; l < LVL; l++)
         for (int n = 0; n < ENTRIES - 1; n++)
            if (int'(p >> (LVL - l)) - 1 == n) touch[n] = ~p[LVL-l-1];
   endfunction

   // Follow the tree from the root to the leaf it currently points at.
   function automatic logic [IDX_W-1:0] plru_leaf(input logic [ENTRIES-2:0] t);
      logic [IDX_W:0] p;
      logic           b;
      p = (IDX_W+1)'(1);
      for (int l = 0; l < LVL; l++) begin
         b = 1'b0;
         for (int n = 0; n < ENTRIES - 1; n++)
            if (int'(p) - 1 == n) b = t[n];
         p = {p[IDX_W-1:0], b};
      end
      return p[IDX_W-1:0];
   endfunction

   // Tag compares for lookup, fill and flush, plus lowest-index encoders.
   always_comb begin
      lu_match = '0;
      up_match = '0;
      fl_match = '0;
      lu_idx   = '0;
      up_idx   = '0;
      inv_idx  = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         lu_match[i] = valid_q[i] && did_q[i] == bus.lu_did_i && (!USE_PID || pid_q[i] == bus.lu_pid_i);
         up_match[i] = valid_q[i] && did_q[i] == bus.up_did_i && (!USE_PID || pid_q[i] == bus.up_pid_i);
         fl_match[i] = !bus.flush_dv_i || (did_q[i] == bus.flush_did_i &&
                       (!USE_PID || !bus.flush_pv_i || pid_q[i] == bus.flush_pid_i));
      end
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (lu_match[i]) lu_idx = IDX_W'(i);
         if (up_match[i]) up_idx = IDX_W'(i);
         if (!valid_q[i]) inv_idx = IDX_W'(i);
      end
   end

   assign do_up    = bus.update_i && !bus.flush_i;
   assign acc      = bus.lu_req_i && !bus.flush_i;
   assign same_tag = bus.up_did_i == bus.lu_did_i && (!USE_PID || bus.up_pid_i == bus.lu_pid_i);
   assign hit      = acc && |lu_match && !(do_up && same_tag);
   assign vic      = |up_match ? up_idx : !(&valid_q) ? inv_idx : plru_leaf(plru_q);
   assign plru_d   = do_up ? touch(plru_q, vic) : hit ? touch(plru_q, lu_idx) : plru_q;

   assign bus.lu_gnt_o     = !bus.flush_i;
   assign bus.lu_valid_o   = lu_valid_q;
   assign bus.lu_hit_o     = lu_hit_q;
   assign bus.lu_content_o = lu_content_q;

   // Valid bits, PLRU tree and the registered lookup response; flush beats fill.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q      <= '0;
         plru_q       <= '0;
         lu_valid_q   <= 1'b0;
         lu_hit_q     <= 1'b0;
         lu_content_q <= '0;
      end else begin
         plru_q       <= plru_d;
         lu_valid_q   <= acc;
         lu_hit_q     <= hit;
         lu_content_q <= hit ? data_q[lu_idx] : '0;
         if (bus.flush_i) valid_q <= valid_q & ~fl_match;
         else if (do_up) valid_q[vic] <= 1'b1;
      end
   end

   // Tag and content storage; only meaningful while the valid bit is set.
   always_ff @(posedge clk_i) begin
      if (do_up) begin
         did_q[vic]  <= bus.up_did_i;
         pid_q[vic]  <= bus.up_pid_i;
         data_q[vic] <= bus.up_content_i;
      end
   end

`ifdef RV_IOMMU_CTX_CACHE_PERF_EN
   // Saturating hit/miss counters on each response; clear wins over increment.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else if (perf_clr_i) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else if (lu_valid_q) begin
         if (lu_hit_q && !(&hit_cnt_o)) hit_cnt_o <= hit_cnt_o + 1'b1;
         if (!lu_hit_q && !(&miss_cnt_o)) miss_cnt_o <= miss_cnt_o + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_rv_iommu_ctx_cache.sv
// tb_rv_iommu_ctx_cache: directed and random checks of the context cache against a behavioural model
module tb_rv_iommu_ctx_cache;
   localparam int ENTRIES   = 4;
   localparam int DID_W     = 4;
   localparam int PID_W     = 3;
   localparam int CONTENT_W = 16;
   localparam int CNT_W     = 2;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic clk_i;
   logic rst_ni;
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   run_chk = 0;
`ifdef RV_IOMMU_CTX_CACHE_PERF_EN
   logic             perf_clr;
   logic [CNT_W-1:0] hit_cnt, miss_cnt;
`endif

   rv_iommu_ctx_cache_if #(.DID_W(DID_W), .PID_W(PID_W), .CONTENT_W(CONTENT_W)) bus ();

   rv_iommu_ctx_cache #(
      .ENTRIES(ENTRIES), .DID_W(DID_W), .PID_W(PID_W),
      .CONTENT_W(CONTENT_W), .USE_PID(1'b1), .CNT_W(CNT_W)
   ) dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (bus)
`ifdef RV_IOMMU_CTX_CACHE_PERF_EN
      ,
      .perf_clr_i(perf_clr),
      .hit_cnt_o (hit_cnt),
      .miss_cnt_o(miss_cnt)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit                   m_v [ENTRIES];
   int                   m_d [ENTRIES];
   int                   m_p [ENTRIES];
   logic [CONTENT_W-1:0] m_c [ENTRIES];
   int                   tr  [ENTRIES-1];
   bit                   e_valid, e_hit;
   logic [CONTENT_W-1:0] e_content;
   int                   e_hc, e_mc;

   function automatic void model_touch(input int leaf);
      int n;
      int p;
      n = leaf + ENTRIES - 1;
      while (n > 0) begin
         p = (n - 1) / 2;
         tr[p] = (n == 2 * p + 1) ? 1 : 0;
         n = p;
      end
   endfunction

   function automatic int model_victim();
      int n;
      n = 0;
      while (n < ENTRIES - 1) n = 2 * n + 1 + tr[n];
      return n - (ENTRIES - 1);
   endfunction

   always @(posedge clk_i or negedge rst_ni) begin : mdl
      int  j, v;
      bit  acc, upd, h;
      if (!rst_ni) begin
         e_valid = 0; e_hit = 0; e_content = '0; e_hc = 0; e_mc = 0;
         for (int k = 0; k < ENTRIES; k++) m_v[k] = 0;
         for (int k = 0; k < ENTRIES - 1; k++) tr[k] = 0;
      end else begin
         acc = bus.lu_req_i && !bus.flush_i;
         upd = bus.update_i && !bus.flush_i;
         j = -1;
         for (int k = 0; k < ENTRIES; k++)
            if (m_v[k] && m_d[k] == int'(bus.lu_did_i) && m_p[k] == int'(bus.lu_pid_i)) j = k;
         h = acc && j >= 0 && !(upd && bus.up_did_i == bus.lu_did_i && bus.up_pid_i == bus.lu_pid_i);
`ifdef RV_IOMMU_CTX_CACHE_PERF_EN
         if (perf_clr) begin
            e_hc = 0; e_mc = 0;
         end else if (e_valid) begin
            if (e_hit) e_hc = (e_hc == CNT_MAX) ? CNT_MAX : e_hc + 1;
            else       e_mc = (e_mc == CNT_MAX) ? CNT_MAX : e_mc + 1;
         end
`endif
         e_valid   = acc;
         e_hit     = h;
         e_content = h ? m_c[j] : '0;
         if (bus.flush_i) begin
            for (int k = 0; k < ENTRIES; k++)
               if (!bus.flush_dv_i || (m_d[k] == int'(bus.flush_did_i) &&
                   (!bus.flush_pv_i || m_p[k] == int'(bus.flush_pid_i)))) m_v[k] = 0;
         end else if (upd) begin
            v = -1;
            for (int k = 0; k < ENTRIES; k++)
               if (m_v[k] && m_d[k] == int'(bus.up_did_i) && m_p[k] == int'(bus.up_pid_i)) v = k;
            if (v < 0)
               for (int k = ENTRIES - 1; k >= 0; k--) if (!m_v[k]) v = k;
            if (v < 0) v = model_victim();
            m_v[v] = 1; m_d[v] = int'(bus.up_did_i); m_p[v] = int'(bus.up_pid_i); m_c[v] = bus.up_content_i;
            model_touch(v);
         end else if (h) begin
            model_touch(j);
         end
      end
   end

   // Every-cycle comparison of the DUT against the model.
   always @(negedge clk_i) begin
      if (rst_ni && run_chk) begin
         chk("gnt", 32'(bus.lu_gnt_o), 32'(!bus.flush_i));
         chk("valid", 32'(bus.lu_valid_o), 32'(e_valid));
         if (e_valid) begin
            chk("hit", 32'(bus.lu_hit_o), 32'(e_hit));
            chk("content", 32'(bus.lu_content_o), 32'(e_content));
         end
`ifdef RV_IOMMU_CTX_CACHE_PERF_EN
         chk("hit_cnt", 32'(hit_cnt), 32'(e_hc));
         chk("miss_cnt", 32'(miss_cnt), 32'(e_mc));
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic fill(input int d, input int p, input logic [CONTENT_W-1:0] c);
      bus.update_i = 1; bus.up_did_i = DID_W'(d); bus.up_pid_i = PID_W'(p); bus.up_content_i = c;
      step();
      bus.update_i = 0;
   endtask

   task automatic flush(input bit dv, input bit pv, input int d, input int p);
      bus.flush_i = 1; bus.flush_dv_i = dv; bus.flush_pv_i = pv;
      bus.flush_did_i = DID_W'(d); bus.flush_pid_i = PID_W'(p);
      step();
      bus.flush_i = 0;
   endtask

   task automatic lookup(input int d, input int p, input bit eh, input logic [CONTENT_W-1:0] ec, input string nm);
      bus.lu_req_i = 1; bus.lu_did_i = DID_W'(d); bus.lu_pid_i = PID_W'(p);
      step();
      bus.lu_req_i = 0;
      @(negedge clk_i);
      chk({nm, " valid"}, 32'(bus.lu_valid_o), 32'd1);
      chk({nm, " hit"}, 32'(bus.lu_hit_o), 32'(eh));
      chk({nm, " content"}, 32'(bus.lu_content_o), 32'(ec));
      #1;
   endtask

   initial begin
      rst_ni = 0;
      bus.flush_i = 0; bus.flush_dv_i = 0; bus.flush_pv_i = 0; bus.flush_did_i = '0; bus.flush_pid_i = '0;
      bus.update_i = 0; bus.up_did_i = '0; bus.up_pid_i = '0; bus.up_content_i = '0;
      bus.lu_req_i = 0; bus.lu_did_i = '0; bus.lu_pid_i = '0;
`ifdef RV_IOMMU_CTX_CACHE_PERF_EN
      perf_clr = 0;
`endif
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset valid", 32'(bus.lu_valid_o), 32'd0);
      chk("reset hit", 32'(bus.lu_hit_o), 32'd0);
      chk("reset content", 32'(bus.lu_content_o), 32'd0);
`ifdef RV_IOMMU_CTX_CACHE_PERF_EN
      chk("reset hit_cnt", 32'(hit_cnt), 32'd0);
      chk("reset miss_cnt", 32'(miss_cnt), 32'd0);
`endif
      rst_ni = 1;
      run_chk = 1;

      fill(1, 2, 16'hA5A5);
      lookup(1, 2, 1, 16'hA5A5, "basic");

      flush(0, 0, 0, 0);
      fill(1, 2, 16'hA5A5);
      fill(1, 3, 16'h0013);
      fill(2, 2, 16'h0022);
      fill(3, 5, 16'h0035);
      lookup(1, 2, 1, 16'hA5A5, "e0");
      lookup(1, 3, 1, 16'h0013, "e1");
      fill(4, 4, 16'h0044);
      lookup(2, 2, 0, 16'h0000, "plru evicted");
      lookup(4, 4, 1, 16'h0044, "plru new");
      lookup(3, 5, 1, 16'h0035, "plru kept");

      fill(1, 2, 16'h1B1B);
      lookup(1, 2, 1, 16'h1B1B, "refill");
      lookup(1, 3, 1, 16'h0013, "refill keep a");
      lookup(4, 4, 1, 16'h0044, "refill keep b");
      lookup(3, 5, 1, 16'h0035, "refill keep c");

      flush(1, 1, 1, 2);
      lookup(1, 2, 0, 16'h0000, "flush pid gone");
      lookup(1, 3, 1, 16'h0013, "flush pid other");
      flush(1, 0, 1, 0);
      lookup(1, 3, 0, 16'h0000, "flush did gone");
      lookup(4, 4, 1, 16'h0044, "flush did other");
      flush(0, 0, 0, 0);
      lookup(4, 4, 0, 16'h0000, "flush all a");
      lookup(3, 5, 0, 16'h0000, "flush all b");

      bus.flush_i = 1; bus.flush_dv_i = 0;
      bus.update_i = 1; bus.up_did_i = 4'd6; bus.up_pid_i = 3'd1; bus.up_content_i = 16'h0061;
      bus.lu_req_i = 1; bus.lu_did_i = 4'd6; bus.lu_pid_i = 3'd1;
      #1;
      chk("flush gnt", 32'(bus.lu_gnt_o), 32'd0);
      step();
      bus.flush_i = 0; bus.update_i = 0; bus.lu_req_i = 0;
      @(negedge clk_i);
      chk("flush no resp", 32'(bus.lu_valid_o), 32'd0);
      #1;
      lookup(6, 1, 0, 16'h0000, "flush dropped fill");

      fill(7, 1, 16'h0071);
      bus.update_i = 1; bus.up_did_i = 4'd7; bus.up_pid_i = 3'd1; bus.up_content_i = 16'h0072;
      bus.lu_req_i = 1; bus.lu_did_i = 4'd7; bus.lu_pid_i = 3'd1;
      step();
      bus.update_i = 0; bus.lu_req_i = 0;
      @(negedge clk_i);
      chk("same tag valid", 32'(bus.lu_valid_o), 32'd1);
      chk("same tag miss", 32'(bus.lu_hit_o), 32'd0);
      #1;
      lookup(7, 1, 1, 16'h0072, "same tag after");

`ifdef RV_IOMMU_CTX_CACHE_PERF_EN
      perf_clr = 1;
      step();
      perf_clr = 0;
      lookup(7, 1, 1, 16'h0072, "perf h1");
      lookup(7, 1, 1, 16'h0072, "perf h2");
      lookup(9, 1, 0, 16'h0000, "perf m1");
      lookup(7, 1, 1, 16'h0072, "perf h3");
      lookup(8, 0, 0, 16'h0000, "perf m2");
      step();
      @(negedge clk_i);
      chk("perf hit_cnt 3", 32'(hit_cnt), 32'd3);
      chk("perf miss_cnt 2", 32'(miss_cnt), 32'd2);
      #1;
      lookup(7, 1, 1, 16'h0072, "perf h4");
      step();
      @(negedge clk_i);
      chk("perf hit_cnt sat", 32'(hit_cnt), 32'd3);
      #1;
      perf_clr = 1;
      step();
      perf_clr = 0;
      @(negedge clk_i);
      chk("perf clr hit", 32'(hit_cnt), 32'd0);
      chk("perf clr miss", 32'(miss_cnt), 32'd0);
      #1;
`endif

      bus.lu_req_i = 1; bus.lu_did_i = 4'd7; bus.lu_pid_i = 3'd1;
      step();
      bus.lu_req_i = 0;
      chk("inflight valid", 32'(bus.lu_valid_o), 32'd1);
      #1;
      rst_ni = 0;
      #1;
      chk("reset kills resp", 32'(bus.lu_valid_o), 32'd0);
      chk("reset kills hit", 32'(bus.lu_hit_o), 32'd0);
      #1;
      rst_ni = 1;
      lookup(7, 1, 0, 16'h0000, "after reset");

      for (int i = 0; i < 3000; i++) begin
         bus.flush_i      = ($urandom_range(99) < 4);
         bus.flush_dv_i   = $urandom_range(1);
         bus.flush_pv_i   = $urandom_range(1);
         bus.flush_did_i  = DID_W'($urandom_range(3));
         bus.flush_pid_i  = PID_W'($urandom_range(1));
         bus.update_i     = ($urandom_range(99) < 30);
         bus.up_did_i     = DID_W'($urandom_range(3));
         bus.up_pid_i     = PID_W'($urandom_range(1));
         bus.up_content_i = CONTENT_W'($urandom);
         bus.lu_req_i     = ($urandom_range(99) < 60);
         bus.lu_did_i     = DID_W'($urandom_range(3));
         bus.lu_pid_i     = PID_W'($urandom_range(1));
`ifdef RV_IOMMU_CTX_CACHE_PERF_EN
         perf_clr         = ($urandom_range(99) < 3);
`endif
         step();
      end
      bus.flush_i = 0; bus.update_i = 0; bus.lu_req_i = 0;
`ifdef RV_IOMMU_CTX_CACHE_PERF_EN
      perf_clr = 0;
`endif
      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
